simon_decrypt: RTL
==================

# simon_decrypt

Iterative Simon block-cipher decryption core, the inverse of the team's Simon encryption core. It has the same `n`/`m` parameterisation and the same key word ordering. It captures a ciphertext and master key, expands the full round-key schedule into local storage, then applies the inverse round function with round keys in reverse order, one round per cycle. It sits beside the encryption core so ciphertext produced by one round-trips through the other.

## Interface
- `n`, default `` `N ``: word size in bits; legal values 16, 24, 32, 48, 64.
- `m`, default `` `M ``: number of key words. Legal (n,m) pairs are (16,4), (24,3), (24,4), (32,3), (32,4), (48,2), (48,3), (64,2), (64,3), (64,4). Any other pair must fail elaboration.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `en`  in  1  start pulse, sampled at rising edge.
- `ciphertext`  in  2n  {x,y}, with x in the upper half.
- `key`  in  n*m  master key; `key[n-1:0]` = k0, `key[(i+1)n-1 -: n]` = ki.
- `plaintext`  out  2n  registered result; upper half is x.
- `done`  out  1  high while in state DONE.

## Operation
- T = rounds(n,m): 32, 36, 36, 42, 44, 52, 54, 68, 69, 72 for the pairs in the order listed above.
- S^j denotes a left rotate by j; f(v) = (S^1 v & S^8 v) ^ S^2 v.
- Storage:
  - ks[0..T-1]: n-bit round keys.
  - x, y: n-bit state.
  - Round counter: 7 bits.
  - ct/key capture registers.
- Key expansion is bit-exact with the encryption core's.
  - tmp = S^-3 k[i-1]; when m=4, tmp ^= k[i-3].
  - tmp ^= S^-1 tmp.
  - k[i] = ~k[i-m] ^ tmp ^ z_j[(i-m) mod 62] ^ 3.
  - z_j is selected per (n,m) as in the Simon specification.
- Inverse round, with key k: x_new = y ^ f(x) ^ k; y_new = x.
  - At DECRYPT entry, the state is {x,y} = {ct_y, ct_x}, i.e. the halves are swapped.
  - At the end, plaintext = {y,x}, i.e. the halves are swapped back.
  - Equivalently, each step undoes one forward round: x = y', y = x' ^ f(y') ^ k.
- States: IDLE, LOAD, EXPAND, DECRYPT, DONE.
  - IDLE: waits for `en`.
  - LOAD:
    - ct and key have already been captured on the `en` edge.
    - ks[0..m-1] are written from the key.
    - counter is set to m.
  - EXPAND: one cycle per key index. Writes ks[counter], then counter += 1. Leaves for DECRYPT when counter = T-1 is written; counter is then set to T-1.
  - DECRYPT: one inverse round per cycle using ks[counter], then counter -= 1. When the round with counter = 0 completes, `plaintext` is registered and the state moves to DONE.
  - DONE: holds `plaintext` and `done` until `en` or `rst`.
- `en` high at any edge, in any state (including mid-EXPAND or mid-DECRYPT), behaves as follows:
  - ct and key are recaptured.
  - `plaintext` is cleared to 0.
  - The state goes to LOAD.
  - The previous operation is abandoned.
- `en` held high keeps the core in LOAD. The operation proceeds from the edge after `en` falls.
- `ciphertext` and `key` are don't-care except on the `en` edge.

## Timing
- Reset: all of the following go to 0 and state goes to IDLE, immediately and independently of `clk`:
  - `plaintext`
  - `done`
  - x, y
  - counter
- The ks array needs no reset.
- Latency: for an `en` sampled at edge E0, `done` rises after edge E(2T-m+1) and `plaintext` is valid in the same cycle.
  - Breakdown: 1 LOAD + (T-m) EXPAND + T DECRYPT.
  - Simon32/64: 61 cycles. Simon64/128: 85 cycles.
- `done` is a decode of the state register, so it is glitch-free and has no combinational path from inputs.
- Reset asserted mid-operation aborts it. After deassertion, the core sits in IDLE with outputs 0 until the next `en`.
- Counter width: 7 bits suffice (T ≤ 72). No wrap occurs; the decrement stops at 0.

## Test plan
- Simon32/64 (n=16, m=4): key = 0x1918_1110_0908_0100, ciphertext = 0xc69be9bb, `en` pulse → plaintext = 0x65656877, `done` rises exactly 61 cycles after the `en` edge.
- Simon64/128 (n=32, m=4): key = 0x1b1a1918_13121110_0b0a0908_03020100, ciphertext = 0x44c8fc20_b9dfa07a → plaintext = 0x656b696c_20646e75, `done` at 85 cycles.
- Round-trip: 200 random key/plaintext pairs for each legal (n,m) are encrypted with the encryption core, then fed to this core → plaintext matches the original bit-for-bit.
- Restart: a second `en` mid-DECRYPT with a new ciphertext → `plaintext` reads 0 the next cycle, `done` stays 0, and the new result appears 2T-m+1 cycles after the second `en`. No contamination from the first run.
- Async reset: `rst` pulsed between clock edges during EXPAND → `done`=0 and `plaintext`=0 before the next edge. A following `en` run produces a correct result.
- DONE hold: after completion, toggle `ciphertext`/`key` with `en`=0 for 20 cycles → `plaintext` and `done`=1 remain unchanged.

Source files
------------

// File: rtl/simon_decrypt.sv
// Iterative Simon decryption core: captures ciphertext/key, expands the full
// round-key schedule into local storage, then runs inverse rounds in reverse key order.
`ifndef N
`define N 16
`endif
`ifndef M
`define M 4
`endif

module simon_decrypt #(
  parameter int n = `N,
  parameter int m = `M
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [2*n-1:0] ciphertext,
  input  logic [n*m-1:0] key,
  output logic [2*n-1:0] plaintext,
  output logic           done
);

  function automatic int rounds_of(input int nn, input int mm);
    if (nn == 16 && mm == 4) return 32;
    if (nn == 24 && mm == 3) return 36;
    if (nn == 24 && mm == 4) return 36;
    if (nn == 32 && mm == 3) return 42;
    if (nn == 32 && mm == 4) return 44;
    if (nn == 48 && mm == 2) return 52;
    if (nn == 48 && mm == 3) return 54;
    if (nn == 64 && mm == 2) return 68;
    if (nn == 64 && mm == 3) return 69;
    if (nn == 64 && mm == 4) return 72;
    return 0;
  endfunction

  // Constant sequences written in reading order: leftmost character is z_j[0].
  function automatic logic [61:0] zstr_of(input int nn, input int mm);
    logic [61:0] z0, z1, z2, z3, z4;
    z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
    z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
    z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
    z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
    z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;
    if (nn == 16) return z0;
    if (nn == 24) return (mm == 3) ? z0 : z1;
    if (nn == 64 && mm == 4) return z4;
    return (mm == 2 || (nn == 32 && mm == 3)) ? z2 : z3;
  endfunction

  function automatic logic [61:0] rev62(input logic [61:0] v);
    logic [61:0] r;
    for (int i = 0; i < 62; i++) r[i] = v[61-i];
    return r;
  endfunction

  localparam int T = rounds_of(n, m);
  localparam int DEPTH = (T > 0) ? T : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [6:0] T_LAST = 7'(T - 1);
  localparam logic [61:0] Z = rev62(zstr_of(n, m));

  generate
    if (T == 0) begin : g_bad_params
      $error("simon_decrypt: unsupported (n,m) combination");
    end
  endgenerate

  function automatic logic [n-1:0] rotl(input logic [n-1:0] v, input int j);
    return (v << j) | (v >> (n - j));
  endfunction

  function automatic logic [n-1:0] round_f(input logic [n-1:0] v);
    return (rotl(v, 1) & rotl(v, 8)) ^ rotl(v, 2);
  endfunction

  typedef enum logic [2:0] {IDLE, LOAD, EXPAND, DECRYPT, DONE} state_t;

  state_t         state;
  logic [2*n-1:0] ct_reg;
  logic [n*m-1:0] key_reg;
  logic [n*m-1:0] kwin;     // last m round keys; word 0 is k[i-m]
  logic [n-1:0]   x, y;
  logic [6:0]     counter;
  logic [n-1:0]   ks [DEPTH];

  logic [n-1:0] tmp0, tmp1, k_new, rk, fx, x_new;
  logic [6:0]   zdiff;
  logic [5:0]   zidx;

  assign zdiff = counter - 7'(m);
  assign zidx  = (zdiff >= 7'd62) ? 6'(zdiff - 7'd62) : zdiff[5:0];

  generate
    if (m == 4) begin : g_m4
      assign tmp0 = rotl(kwin[n*m-1 -: n], n - 3) ^ kwin[n +: n];
    end else begin : g_m23
      assign tmp0 = rotl(kwin[n*m-1 -: n], n - 3);
    end
  endgenerate

  assign tmp1  = tmp0 ^ rotl(tmp0, n - 1);
  assign k_new = ~kwin[n-1:0] ^ tmp1 ^ {{(n-2){1'b0}}, 1'b1, ~Z[zidx]};
  assign rk    = ks[counter[AW-1:0]];
  assign fx    = round_f(x);
  assign x_new = y ^ fx ^ rk;
  assign done  = (state == DONE);

  // Round-key storage carries no reset; it is always rewritten before use.
  always_ff @(posedge clk) begin
    if (!en && state == LOAD) begin
      for (int i = 0; i < m; i++) ks[i] <= key_reg[i*n +: n];
    end else if (!en && state == EXPAND) begin
      ks[counter[AW-1:0]] <= k_new;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      plaintext <= '0;
      x         <= '0;
      y         <= '0;
      counter   <= '0;
      ct_reg    <= '0;
      key_reg   <= '0;
      kwin      <= '0;
    end else if (en) begin
      state     <= LOAD;
      ct_reg    <= ciphertext;
      key_reg   <= key;
      plaintext <= '0;
    end else begin
      case (state)
        LOAD: begin
          kwin    <= key_reg;
          x       <= ct_reg[n-1:0];
          y       <= ct_reg[2*n-1:n];
          counter <= 7'(m);
          state   <= EXPAND;
        end
        EXPAND: begin
          kwin <= {k_new, kwin[n*m-1:n]};
          if (counter == T_LAST) state <= DECRYPT;
          else counter <= counter + 7'd1;
        end
        DECRYPT: begin
          x <= x_new;
          y <= x;
          if (counter == 7'd0) begin
            plaintext <= {x, x_new};
            state     <= DONE;
          end else begin
            counter <= counter - 7'd1;
          end
        end
        IDLE, DONE: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
